weight_pingpong_buffer: RTL

WEIGHT_PINGPONG_BUFFER -- requirements
Module: weight_pingpong_buffer

---
 rtl/npu_wbuf_pkg.sv | 23 ++
 rtl/sram_sp.sv | 41 ++++
 rtl/weight_pingpong_buffer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/npu_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npu_wbuf_pkg
// Purpose  : Shared constants and types for the weight ping-pong buffer.
//            c_rd_latency - clock edges from read-request acceptance to the
//                           response beat on rd_data/rd_data_valid.
//            bank_idx_t   - index of one of the two weight banks.
// Revision : 1.0 - initial release
// ============================================================================
package npu_wbuf_pkg;

  // Edges between request acceptance and the response beat. The read
  // datapath (SRAM read, staging register, output register) is built for 2.
  localparam int c_rd_latency = 2;

  // Number of banks in the ping-pong arrangement.
  localparam int c_num_banks = 2;

  // One bit selects between the two banks.
  typedef logic bank_idx_t;

endpackage : npu_wbuf_pkg
`default_nettype wire

// File: rtl/sram_sp.sv
`default_nettype none
// ============================================================================
// Module   : sram_sp
// Purpose  : Single-port synchronous SRAM model, one access per cycle.
//            A read returns mem[addr] on rdata after the clock edge; a write
//            leaves rdata unchanged. Contents are not reset.
// Ports    : clk   - clock
//            en    - access enable
//            we    - write enable (qualified by en)
//            addr  - word address
//            wdata - write data
//            rdata - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module sram_sp #(
  parameter int WIDTH      = 128,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule : sram_sp
`default_nettype wire

// File: rtl/weight_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : weight_pingpong_buffer
// Purpose  : Two-bank weight buffer. The loader fills bank fill_sel while the
//            compute array reads bank ~fill_sel. A bank becomes full after a
//            write carrying wr_last and is released by rd_done; the banks swap
//            roles once the fill bank is full and the read bank is free.
// Ports    : clk, rst_n (async, active-low)
//            wr_valid/wr_ready/wr_addr/wr_data/wr_last - loader write channel
//            rd_valid/rd_ready/rd_addr                 - read request channel
//            rd_data/rd_data_valid/rd_parity_err       - read response, fixed
//                                                        2-edge latency
//            rd_done   - consumer releases the read bank
//            fill_sel  - index of the bank being filled
//            bank_full - per-bank full flags
// Config   : WBUF_PARITY_EN - when defined, each word carries an even-parity
//            bit checked on readout; otherwise rd_parity_err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module weight_pingpong_buffer
  import npu_wbuf_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_parity_err,
  input  logic                  rd_done,
  output logic                  fill_sel,
  output logic [1:0]            bank_full
);

`ifdef WBUF_PARITY_EN
  localparam int c_sram_width = DATA_WIDTH + 1;
`else
  localparam int c_sram_width = DATA_WIDTH;
`endif

  // --------------------------------------------------------------------------
  // Bank control
  // --------------------------------------------------------------------------
  bank_idx_t                 r_fill_sel;
  logic [c_num_banks-1:0]    r_bank_full;
  bank_idx_t                 w_rd_bank;
  logic                      w_wr_ready;
  logic                      w_rd_ready;
  logic                      w_wr_fire;
  logic                      w_rd_fire;
  logic                      w_swap;

  assign w_rd_bank  = ~r_fill_sel;
  assign w_wr_ready = ~r_bank_full[r_fill_sel];
  assign w_rd_ready = r_bank_full[w_rd_bank];
  assign w_wr_fire  = wr_valid & w_wr_ready;
  assign w_rd_fire  = rd_valid & w_rd_ready;

  // Swap looks only at the registered flags, so a wr_last or rd_done in the
  // current cycle takes effect one cycle before the swap can follow.
  assign w_swap = r_bank_full[r_fill_sel] & ~r_bank_full[w_rd_bank];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_sel  <= 1'b0;
      r_bank_full <= '0;
    end else begin
      if (w_swap) begin
        r_fill_sel <= ~r_fill_sel;
      end
      // Set and clear always address different banks, so they never collide.
      if (w_wr_fire && wr_last) begin
        r_bank_full[r_fill_sel] <= 1'b1;
      end
      if (rd_done && r_bank_full[w_rd_bank]) begin
        r_bank_full[w_rd_bank] <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage: one single-port SRAM per bank. A bank is either the write target
  // or the read target in a given cycle, never both.
  // --------------------------------------------------------------------------
  logic [c_sram_width-1:0] w_wr_word;
  logic [c_sram_width-1:0] w_bank_rdata [c_num_banks];

`ifdef WBUF_PARITY_EN
  // Even parity: the stored word always holds an even number of ones.
  assign w_wr_word = {^wr_data, wr_data};
`else
  assign w_wr_word = wr_data;
`endif

  for (genvar i = 0; i < c_num_banks; i++) begin : g_bank
    logic                  w_we;
    logic                  w_re;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_we   = w_wr_fire & (r_fill_sel == 1'(i));
    assign w_re   = w_rd_fire & (w_rd_bank == 1'(i));
    assign w_addr = w_we ? wr_addr : rd_addr;

    sram_sp #(
      .WIDTH      (c_sram_width),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
      .clk   (clk),
      .en    (w_we | w_re),
      .we    (w_we),
      .addr  (w_addr),
      .wdata (w_wr_word),
      .rdata (w_bank_rdata[i])
    );
  end

  // --------------------------------------------------------------------------
  // Read pipeline.
  //   edge N   : request accepted, SRAM read        -> r_vld_pipe[0]
  //   edge N+1 : SRAM word captured (parity check)  -> r_vld_pipe[1]
  //   edge N+2 : response presented                 -> r_vld_pipe[2]
  // The bank index travels with the request, so a release or swap after
  // acceptance does not disturb a read already in flight.
  // --------------------------------------------------------------------------
  logic [c_rd_latency:0]   r_vld_pipe;
  bank_idx_t               r_s1_bank;
  logic [c_sram_width-1:0] w_s1_word;
  logic [DATA_WIDTH-1:0]   r_s2_data;
  logic [DATA_WIDTH-1:0]   r_rd_data;

  assign w_s1_word = w_bank_rdata[r_s1_bank];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1_bank  <= 1'b0;
      r_s2_data  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[c_rd_latency-1:0], w_rd_fire};
      if (w_rd_fire) begin
        r_s1_bank <= w_rd_bank;
      end
      if (r_vld_pipe[0]) begin
        r_s2_data <= w_s1_word[DATA_WIDTH-1:0];
      end
      // rd_data holds its last value between beats.
      if (r_vld_pipe[1]) begin
        r_rd_data <= r_s2_data;
      end
    end
  end

`ifdef WBUF_PARITY_EN
  logic r_s2_err;
  logic r_rd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_err <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      if (r_vld_pipe[0]) begin
        // Odd ones-count across data+parity means a flipped bit.
        r_s2_err <= ^w_s1_word;
      end
      // Error is only reported alongside a valid beat.
      r_rd_err <= r_vld_pipe[1] & r_s2_err;
    end
  end

  assign rd_parity_err = r_rd_err;
`else
  assign rd_parity_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign wr_ready      = w_wr_ready;
  assign rd_ready      = w_rd_ready;
  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_vld_pipe[c_rd_latency];
  assign fill_sel      = r_fill_sel;
  assign bank_full     = r_bank_full;

endmodule : weight_pingpong_buffer
`default_nettype wire
